mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Memory-access sequencer between the control unit and the 512x32 RAM.
//   Holds the MAR/MDR values for the whole transfer and drives the RAM read/write strobes.
//   Captures the RAM read data into the MDR path and returns a one-cycle done pulse.
//   The control unit never drives RAM strobes directly.
// PARAMETERS
//   DEPTH        512  number of valid RAM words; addr >= DEPTH is out of range
//   WAIT_CYCLES  2    clock cycles the strobe/address/data stay asserted (>=1)
// PORTS
//   clock     in   1   system clock (posedge logic; the RAM samples on negedge)
//   reset     in   1   asynchronous, active-high reset
//   req       in   1   access request from control unit; sampled in IDLE only
//   wr_en     in   1   1 = write, 0 = read; sampled with req
//   addr      in   32  word address (MAR value); sampled with req
//   wdata     in   32  write data (MDR value); sampled with req
//   busy      out  1   high from accept edge until return to IDLE
//   done      out  1   one-cycle completion pulse
//   rdata     out  32  read result (to MDR MDataIN); holds until next read completes
//   addr_err  out  1   set with done when addr >= DEPTH; cleared on next accept
//   ram_read  out  1   RAM read strobe
//   ram_write out  1   RAM write strobe
//   ram_addr  out  32  RAM Address
//   ram_data  out  32  RAM data (write data)
//   ram_out   in   32  RAM RAMout
// BEHAVIOUR
//   Reset (async) sets: state=IDLE, all outputs 0, counter 0. Strobes drop immediately,
//     including mid-transfer. No partial completion: done is not pulsed.
//   Outputs are registered only; no combinational path from req to ram_* or done.
//   FSM: IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE.
//   IDLE: on posedge with req=1:
//     - latch addr/wdata into ram_addr/ram_data; busy<=1; addr_err<=0.
//     - In range: ram_read<=~wr_en, ram_write<=wr_en; go to ACCESS; counter<=WAIT_CYCLES-1.
//     - Out of range: no strobe; addr_err<=1; go straight to DONE.
//   ACCESS: strobes/addr/data held stable; counter decrements each edge.
//     At counter==0: go to CAPTURE and drop both strobes.
//   CAPTURE: if read, rdata<=ram_out. If write, rdata unchanged. Go to DONE.
//   DONE: done=1 for exactly this cycle; busy still 1; next edge -> IDLE, busy<=0, done<=0.
//   Latency (in range): req accepted at edge N; done high after edge N+WAIT_CYCLES+1,
//     low after N+WAIT_CYCLES+2. Out of range: done after edge N+1.
//   ram_read and ram_write are never high together.
//   req while busy is ignored (not queued). Minimum one IDLE cycle between transfers.
//   Address compare uses the full 32 bits (no truncation/wrap); ram_addr passes all 32 bits.
//   Timing: the RAM updates RAMout at negedge+#5, so the clock period must be >10 time units
//     for CAPTURE to see valid data.
// TESTING
//   1. Reset, then write addr=90 wdata=85 -> ram_write high WAIT_CYCLES cycles,
//      done after edge 3 (WAIT=2), addr_err=0.
//   2. Read addr=90 -> ram_read only, rdata=85 with done. Read addr=133 (preload) -> rdata=16.
//   3. Read addr=512 -> no strobe, done after 1 edge, addr_err=1, rdata unchanged.
//   4. req held high during busy with a different addr -> ignored, ram_addr stable,
//      single done pulse.
//   5. Assert reset mid-ACCESS -> strobes/busy 0 immediately, no done; next read of
//      addr 90 returns 85.
//   6. WAIT_CYCLES=1 build: read addr 133 -> done after edge N+2, rdata=16.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-access sequencer between control unit and 512x32 RAM
//
// Sequences one RAM read or write per request. Address and write data are
// held on ram_addr/ram_data for the whole transfer. The RAM read/write
// strobes are driven from here only. Read data is captured into rdata, and
// done is pulsed for one cycle at the end of each transfer.
//
// Ports
//   clock      in   system clock (posedge logic; the RAM samples on negedge)
//   reset      in   asynchronous active-high reset
//   req        in   access request, sampled in IDLE only
//   wr_en      in   1 = write, 0 = read, sampled with req
//   addr       in   32-bit word address, sampled with req
//   wdata      in   32-bit write data, sampled with req
//   busy       out  high from the accept edge until the return to IDLE
//   done       out  one-cycle completion pulse
//   rdata      out  last read result, held until the next read completes
//   addr_err   out  out-of-range flag for the current/last transfer
//   ram_read   out  RAM read strobe
//   ram_write  out  RAM write strobe
//   ram_addr   out  RAM address
//   ram_data   out  RAM write data
//   ram_out    in   RAM read data

module mem_access_ctrl #(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        ram_read,
    output logic        ram_write,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_out
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          addr_err_q, addr_err_d;
    logic          ram_read_q, ram_read_d;
    logic          ram_write_q, ram_write_d;
    logic [31:0]   ram_addr_q, ram_addr_d;
    logic [31:0]   ram_data_q, ram_data_d;
    // Remembers that a real read was issued, so CAPTURE knows whether to
    // load rdata after the strobe has already dropped.
    logic          rd_pend_q, rd_pend_d;

    logic          in_range;

    // Full 32-bit compare: high address bits never alias into the RAM.
    assign in_range = (addr < 32'(DEPTH));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        addr_err_d  = addr_err_q;
        ram_read_d  = ram_read_q;
        ram_write_d = ram_write_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        rd_pend_d   = rd_pend_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    ram_addr_d = addr;
                    ram_data_d = wdata;
                    busy_d     = 1'b1;
                    addr_err_d = 1'b0;
                    if (in_range) begin
                        ram_read_d  = ~wr_en;
                        ram_write_d = wr_en;
                        rd_pend_d   = ~wr_en;
                        cnt_d       = CW'(WAIT_CYCLES - 1);
                        state_d     = ACCESS;
                    end else begin
                        // No strobe. Passing through CAPTURE with nothing
                        // pending leaves rdata alone, and done lands one
                        // edge after the accept.
                        addr_err_d = 1'b1;
                        rd_pend_d  = 1'b0;
                        state_d    = CAPTURE;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    ram_read_d  = 1'b0;
                    ram_write_d = 1'b0;
                    state_d     = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            CAPTURE: begin
                if (rd_pend_q) begin
                    rdata_d = ram_out;
                end
                rd_pend_d = 1'b0;
                done_d    = 1'b1;
                state_d   = DONE;
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                ram_read_d  = 1'b0;
                ram_write_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            addr_err_q  <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            addr_err_q  <= addr_err_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign addr_err  = addr_err_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed scoreboard bench for mem_access_ctrl

module tb_mem_access_ctrl;

    localparam int W0 = 2;
    localparam int W1 = 1;

    logic clock = 1'b0;
    always #10 clock = ~clock;

    logic        reset;
    logic        req, wr_en;
    logic [31:0] addr, wdata;
    logic        busy, done, addr_err, ram_read, ram_write;
    logic [31:0] rdata, ram_addr, ram_data, ram_out;

    logic        req1, wr_en1;
    logic [31:0] addr1, wdata1;
    logic        busy1, done1, addr_err1, ram_read1, ram_write1;
    logic [31:0] rdata1, ram_addr1, ram_data1, ram_out1;

    mem_access_ctrl #(.DEPTH(512), .WAIT_CYCLES(W0)) dut0 (
        .clock(clock), .reset(reset), .req(req), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .addr_err(addr_err), .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_out(ram_out)
    );

    mem_access_ctrl #(.DEPTH(512), .WAIT_CYCLES(W1)) dut1 (
        .clock(clock), .reset(reset), .req(req1), .wr_en(wr_en1), .addr(addr1),
        .wdata(wdata1), .busy(busy1), .done(done1), .rdata(rdata1),
        .addr_err(addr_err1), .ram_read(ram_read1), .ram_write(ram_write1),
        .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_out(ram_out1)
    );

    logic [31:0] mem     [0:511];
    logic [31:0] ref_mem [0:511];

    initial ram_out  = '0;
    initial ram_out1 = '0;

    always @(negedge clock) begin
        if (ram_write) mem[ram_addr[8:0]] = ram_data;
        if (ram_read) begin
            #5;
            ram_out = mem[ram_addr[8:0]];
        end
    end

    always @(negedge clock) begin
        if (ram_read1) begin
            #5;
            ram_out1 = mem[ram_addr1[8:0]];
        end
    end

    int done_cnt = 0;
    always @(negedge clock) if (done) done_cnt++;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_rdata;
    int          vectors    = 0;
    int          miscompares = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer on dut0 from IDLE, checks latency, strobe width,
    // address stability and the scoreboard entry at done.
    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic hold, input string tag);
        logic inr;
        int   cycles, stb, both, addr_bad, d0;
        exp_t e;
        inr = (a < 32'd512);
        if (we && inr) ref_mem[a[8:0]] = d;
        if (!we && inr) model_rdata = ref_mem[a[8:0]];
        sb_q.push_back('{rdata: model_rdata, err: !inr});
        d0 = done_cnt;

        req = 1'b1; wr_en = we; addr = a; wdata = d;
        tick();
        if (hold) addr = a ^ 32'h0000_0041;
        else req = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        cycles = 0; stb = 0; both = 0; addr_bad = 0;
        if (we ? ram_write : ram_read) stb++;
        if (ram_read && ram_write) both = 1;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
            if (we ? ram_write : ram_read) stb++;
            if (ram_read && ram_write) both = 1;
            if (ram_addr !== a) addr_bad = 1;
        end
        req = 1'b0;
        chk({tag, "_lat"}, 32'(cycles), inr ? 32'(W0 + 1) : 32'd1);
        chk({tag, "_stb"}, 32'(stb), inr ? 32'(W0) : 32'd0);
        chk({tag, "_both"}, 32'(both), 32'd0);
        chk({tag, "_addr"}, 32'(addr_bad), 32'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_rdata"}, rdata, e.rdata);
            chk({tag, "_err"}, 32'(addr_err), 32'(e.err));
        end
        tick();
        chk({tag, "_done_lo"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int   cycles, stb, d0;
        exp_t e;

        for (int i = 0; i < 512; i++) mem[i] = 32'(i) ^ 32'h5A00_0000;
        mem[133] = 32'd16;
        mem[511] = 32'hA5A5_0511;
        for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];
        model_rdata = '0;

        reset = 1'b1;
        req = 0; wr_en = 0; addr = 0; wdata = 0;
        req1 = 0; wr_en1 = 0; addr1 = 0; wdata1 = 0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_rd", 32'(ram_read), 32'd0);
        chk("rst_wr", 32'(ram_write), 32'd0);
        chk("rst_addr", ram_addr, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        xfer(1'b1, 32'd90, 32'd85, 1'b0, "wr90");
        xfer(1'b0, 32'd90, 32'd0, 1'b0, "rd90");
        chk("rd90_val", rdata, 32'd85);
        xfer(1'b0, 32'd133, 32'd0, 1'b0, "rd133");
        chk("rd133_val", rdata, 32'd16);
        xfer(1'b0, 32'd511, 32'd0, 1'b0, "rd511");
        xfer(1'b0, 32'd512, 32'd0, 1'b0, "rd512");
        chk("rd512_keep", rdata, 32'hA5A5_0511);
        xfer(1'b0, 32'h0001_005A, 32'd0, 1'b0, "rdhi");
        xfer(1'b1, 32'd600, 32'hDEAD_BEEF, 1'b0, "wr600");
        xfer(1'b0, 32'd90, 32'd0, 1'b1, "hold90");

        // Reset in the middle of ACCESS.
        req = 1'b1; wr_en = 1'b0; addr = 32'd133;
        tick();
        req = 1'b0;
        chk("mid_rd_on", 32'(ram_read), 32'd1);
        d0 = done_cnt;
        #3 reset = 1'b1;
        #1;
        chk("mid_rd_off", 32'(ram_read), 32'd0);
        chk("mid_wr_off", 32'(ram_write), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rdata", rdata, 32'd0);
        model_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_done_lo", 32'(done), 32'd0);
        xfer(1'b0, 32'd90, 32'd0, 1'b0, "rd90_post");
        chk("rd90_post_val", rdata, 32'd85);

        // WAIT_CYCLES = 1 instance.
        sb_q.push_back('{rdata: 32'd16, err: 1'b0});
        req1 = 1'b1; wr_en1 = 1'b0; addr1 = 32'd133;
        tick();
        req1 = 1'b0;
        cycles = 0;
        stb = ram_read1 ? 1 : 0;
        while (!done1 && cycles < 20) begin
            tick();
            cycles++;
            if (ram_read1) stb++;
        end
        chk("w1_lat", 32'(cycles), 32'(W1 + 1));
        chk("w1_stb", 32'(stb), 32'(W1));
        if (sb_q.size() == 0) begin
            chk("w1_sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("w1_rdata", rdata1, e.rdata);
            chk("w1_err", 32'(addr_err1), 32'(e.err));
        end
        tick();
        chk("w1_done_lo", 32'(done1), 32'd0);
        chk("w1_idle", 32'(busy1), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
